// File: rtl/scanchain_writer_mc_if.sv
// Write-request / read-response bundle between the scan client and the
// multi-chain scan writer.
interface scanchain_writer_mc_if #(
    parameter int CHAN_BITS    = 1,
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169
);
    logic                    write_valid;
    logic                    write_ready;
    logic [CHAN_BITS-1:0]    write_chan;
    logic [ADDR_BITS-1:0]    write_addr;
    logic [PAYLOAD_BITS-1:0] write_payload;
    logic                    write_reset;
    logic                    read_valid;
    logic                    read_ready;
    logic [PAYLOAD_BITS-1:0] read_data;

    modport master (
        output write_valid, write_chan, write_addr, write_payload, write_reset,
        output read_ready,
        input  write_ready, read_valid, read_data
    );

    modport slave (
        input  write_valid, write_chan, write_addr, write_payload, write_reset,
        input  read_ready,
        output write_ready, read_valid, read_data
    );
endinterface

// File: rtl/scanchain_writer_mc.sv
// Multi-channel scan chain writer. Shifts {addr, payload} MSB first into one
// of NUM_CHAINS chains, captures that chain's scan_out while shifting and
// returns the last PAYLOAD_BITS samples as a read response. A write with
// write_reset set pulses that chain's scan_reset for one scan_clk period.
//
// state  | meaning
// IDLE   | write_ready high, waiting for a request
// PULSE  | scan_reset high on the selected chain for D cycles
// SHIFT  | F bit periods of scan_clk with scan_en, capturing scan_out
// UPDATE | one extra scan_clk period with scan_en low to latch the chain
// RESP   | read_valid high until the consumer takes read_data
module scanchain_writer_mc #(
    parameter int NUM_CHAINS        = 2,
    parameter int CHAN_BITS         = 1,
    parameter int ADDR_BITS         = 12,
    parameter int PAYLOAD_BITS      = 169,
    parameter int CLKS_PER_SCAN_CLK = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    scanchain_writer_mc_if.slave  bus,
    output logic [NUM_CHAINS-1:0] scan_clk,
    output logic [NUM_CHAINS-1:0] scan_en,
    output logic [NUM_CHAINS-1:0] scan_in,
    output logic [NUM_CHAINS-1:0] scan_reset,
    input  logic [NUM_CHAINS-1:0] scan_out
);
    localparam int F  = ADDR_BITS + PAYLOAD_BITS;
    localparam int D  = CLKS_PER_SCAN_CLK;
    localparam int PW = $clog2(D);
    localparam int BW = $clog2(F);

    // Phase is a down-counter over one bit period: D-1 on the first cycle,
    // 0 on the last. scan_clk is high while phase <= D/2-1.
    localparam logic [PW-1:0] PHASE_LAST = PW'(D - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(D / 2);
    localparam logic [PW-1:0] PHASE_RISE = PW'(D / 2 - 1);
    localparam logic [BW-1:0] BITS_LAST  = BW'(F - 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SHIFT,
        UPDATE,
        RESP
    } state_t;

    state_t                  state;
    logic                    write_ready_q;
    logic                    read_valid_q;
    logic [PAYLOAD_BITS-1:0] read_data_q;
    logic [NUM_CHAINS-1:0]   chan_oh;
    logic [NUM_CHAINS-1:0]   req_oh;
    logic                    req_ok;
    logic [F-1:0]            frame_sr;
    logic [PAYLOAD_BITS-1:0] capture_sr;
    logic [PW-1:0]           phase;
    logic [BW-1:0]           bits_left;

    assign bus.write_ready = write_ready_q;
    assign bus.read_valid  = read_valid_q;
    assign bus.read_data   = read_data_q;

    // Decode the requested channel; out-of-range channels decode to no chain.
    always_comb begin
        req_oh = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            req_oh[i] = (bus.write_chan == CHAN_BITS'(i));
        end
    end

    assign req_ok = |req_oh;

    // Sequencer: all scan outputs and handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            write_ready_q <= 1'b0;
            read_valid_q  <= 1'b0;
            read_data_q   <= '0;
            chan_oh       <= '0;
            frame_sr      <= '0;
            capture_sr    <= '0;
            phase         <= '0;
            bits_left     <= '0;
            scan_clk      <= '0;
            scan_en       <= '0;
            scan_in       <= '0;
            scan_reset    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_ready_q <= 1'b1;
                    // Requests to a missing chain are swallowed without leaving IDLE.
                    if (write_ready_q && bus.write_valid && req_ok) begin
                        write_ready_q <= 1'b0;
                        chan_oh       <= req_oh;
                        phase         <= PHASE_LAST;
                        if (bus.write_reset) begin
                            state      <= PULSE;
                            scan_reset <= req_oh;
                        end else begin
                            state     <= SHIFT;
                            scan_en   <= req_oh;
                            scan_in   <= bus.write_addr[ADDR_BITS-1] ? req_oh : '0;
                            frame_sr  <= {bus.write_addr, bus.write_payload};
                            bits_left <= BITS_LAST;
                        end
                    end
                end

                PULSE: begin
                    if (phase == '0) begin
                        scan_reset    <= '0;
                        write_ready_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                SHIFT: begin
                    if (phase == PHASE_RISE) begin
                        capture_sr <= {capture_sr[PAYLOAD_BITS-2:0], |(scan_out & chan_oh)};
                    end
                    if (phase == '0) begin
                        phase    <= PHASE_LAST;
                        scan_clk <= '0;
                        if (bits_left == '0) begin
                            state   <= UPDATE;
                            scan_en <= '0;
                            scan_in <= '0;
                        end else begin
                            bits_left <= bits_left - 1'b1;
                            frame_sr  <= frame_sr << 1;
                            scan_in   <= frame_sr[F-2] ? chan_oh : '0;
                        end
                    end else begin
                        phase    <= phase - 1'b1;
                        scan_clk <= (phase <= PHASE_HALF) ? chan_oh : '0;
                    end
                end

                UPDATE: begin
                    if (phase == '0) begin
                        scan_clk     <= '0;
                        read_valid_q <= 1'b1;
                        read_data_q  <= capture_sr;
                        state        <= RESP;
                    end else begin
                        phase    <= phase - 1'b1;
                        scan_clk <= (phase <= PHASE_HALF) ? chan_oh : '0;
                    end
                end

                RESP: begin
                    if (bus.read_ready) begin
                        read_valid_q  <= 1'b0;
                        write_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
